// File: rtl/mat_stream_src_if.sv
// rtl/mat_stream_src_if.sv - AXI-Stream-like channel bundle for mat_stream_src
// Signals: tdata (DW), tvalid, tlast driven by the master; tready driven by the slave.
interface mat_stream_src_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mat_stream_src.sv
// rtl/mat_stream_src.sv - streams an NxN matrix row-major and collects N result words
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  matrix write port, honoured only while idle
//   start                  begin one stream/collect pass
//   busy, done, err        pass in progress, one-cycle completion pulse, sticky framing error
//   m_axis (master)        matrix elements, tlast on the last column of each row
//   s_axis (slave)         result words from the multiplier
//   res_rd_addr/data       result buffer readback, one cycle latency
module mat_stream_src #(
  parameter int N  = 2,
  parameter int DW = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [$clog2(N*N)-1:0]   wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  mat_stream_src_if.master         m_axis,
  mat_stream_src_if.slave          s_axis,
  input  logic [$clog2(N)-1:0]     res_rd_addr,
  output logic [DW-1:0]            res_rd_data
);

  localparam int NN  = N * N;
  localparam int AW  = $clog2(NN);
  localparam int CW  = $clog2(N);
  localparam int RW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [AW-1:0]   r_idx;        // linear index of the element currently presented
  logic [RW1-1:0]  r_res_idx;
  logic            r_err;
  logic            r_src_done;
  logic            r_tvalid;
  logic [DW-1:0]   r_tdata;
  logic            r_tlast;
  logic            r_s_tready;
  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_rd_data;

  logic [DW-1:0]   r_mem [NN];
  logic [DW-1:0]   r_res [N];

  logic w_m_hs, w_m_last, w_src_fin, w_s_hs, w_res_last, w_complete;
  logic w_to_done, w_to_flush, w_mem_we, w_res_we, w_col_wrap;

  assign w_m_hs     = r_tvalid && m_axis.tready;
  assign w_m_last   = (r_idx == AW'(NN - 1));
  // Source counts as finished in the very cycle its final beat is accepted.
  assign w_src_fin  = r_src_done || (w_m_hs && w_m_last);
  assign w_s_hs     = r_s_tready && s_axis.tvalid;
  assign w_res_last = (r_res_idx == RW1'(N - 1));
  assign w_complete = (r_state == RUN) && w_s_hs && (w_res_last || s_axis.tlast);
  assign w_to_done  = w_src_fin && (w_complete || (r_state == FLUSH));
  assign w_to_flush = w_complete && !w_src_fin;
  assign w_mem_we   = wr_en && (r_state == IDLE) && (int'(wr_addr) < NN);
  // Late beats in FLUSH beyond the buffer are accepted but dropped.
  assign w_res_we   = w_s_hs && (r_res_idx < RW1'(N));
  assign w_col_wrap = (r_col == CW'(N - 1));

  always_ff @(posedge aclk) begin
    if (w_mem_we) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge aclk) begin
    if (w_res_we) r_res[r_res_idx[CW-1:0]] <= s_axis.tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rd_data <= '0;
    else          r_rd_data <= r_res[res_rd_addr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_idx      <= '0;
      r_res_idx  <= '0;
      r_err      <= 1'b0;
      r_src_done <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_s_tready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_row      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_res_idx  <= '0;
            r_err      <= 1'b0;
            r_src_done <= 1'b0;
            r_tvalid   <= 1'b1;
            r_tdata    <= r_mem[0];
            r_tlast    <= 1'b0;
            r_s_tready <= 1'b1;
          end
        end
        RUN, FLUSH: begin
          // Source: preload the next element on each accepted beat.
          if (w_m_hs) begin
            if (w_m_last) begin
              r_tvalid   <= 1'b0;
              r_tlast    <= 1'b0;
              r_src_done <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_tdata <= r_mem[r_idx + 1'b1];
              r_col   <= w_col_wrap ? '0 : r_col + 1'b1;
              r_row   <= w_col_wrap ? r_row + 1'b1 : r_row;
              r_tlast <= !w_col_wrap && (r_col == CW'(N - 2));
            end
          end
          // Sink: framing is only judged while the pass is still collecting.
          if (w_res_we) r_res_idx <= r_res_idx + 1'b1;
          if ((r_state == RUN) && w_s_hs && (s_axis.tlast != w_res_last)) r_err <= 1'b1;
          if (w_to_done) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_s_tready <= 1'b0;
          end else if (w_to_flush) begin
            r_state <= FLUSH;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign s_axis.tready = r_s_tready;
  assign res_rd_data   = r_rd_data;

endmodule
